// File: rtl/mult_share_ctrl.sv
// ============================================================================
// Module   : mult_share_ctrl
// Purpose  : Round-robin arbiter/sequencer sharing one 32x32->64 signed
//            multiplier among NREQ requesters. Optional watchdog: MULT_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] a_in,
    input  logic [NREQ*32-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [63:0]        result,
    output logic               err,
    output logic               mul_en,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic               mul_busy,
    input  logic [63:0]        mul_r
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] C_NREQ = (PW+1)'(NREQ);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    logic [2:0]      r_state;
    logic [PW-1:0]   r_ptr;
    logic            w_found;
    logic [PW-1:0]   w_winner;
    logic [NREQ-1:0] w_gnt;
    logic            w_timeout;
    logic [31:0]     w_a_arr [NREQ];
    logic [31:0]     w_b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign w_a_arr[i] = a_in[32*i+31 -: 32];
        assign w_b_arr[i] = b_in[32*i+31 -: 32];
    end

    // Scan starts one past the last winner so a re-requesting owner ranks last.
    always_comb begin
        logic [PW:0] w_scan;
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_scan   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_scan >= C_NREQ) begin
                w_scan = w_scan - C_NREQ;
            end
            if (!w_found && req[w_scan[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[PW-1:0];
            end
        end
    end

    assign w_gnt = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

`ifdef MULT_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 255) ? 16 : 8;

    logic [TW-1:0] r_wdog;
    logic          w_waiting;

    assign w_waiting = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
    // A normal completion in the expiry cycle wins over the watchdog.
    assign w_timeout = w_waiting && (r_wdog == TW'(TIMEOUT - 1)) &&
                       !((r_state == ST_WAIT_DONE) && !mul_busy);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            err    <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE) begin
                r_wdog <= '0;
            end else if (w_waiting) begin
                r_wdog <= r_wdog + TW'(1);
            end
            if (w_timeout) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= PW'(NREQ - 1);
            gnt     <= '0;
            done    <= '0;
            result  <= '0;
            mul_en  <= 1'b0;
            mul_a   <= '0;
            mul_b   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        gnt     <= w_gnt;
                        r_ptr   <= w_winner;
                        mul_a   <= w_a_arr[w_winner];
                        mul_b   <= w_b_arr[w_winner];
                        mul_en  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mul_en  <= 1'b0;
                    r_state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (w_timeout) begin
                        result  <= '0;
                        done    <= gnt;
                        r_state <= ST_RESP;
                    end else if (mul_busy) begin
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!mul_busy) begin
                        result  <= mul_r;
                        done    <= gnt;
                        r_state <= ST_RESP;
                    end else if (w_timeout) begin
                        result  <= '0;
                        done    <= gnt;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    done    <= '0;
                    gnt     <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
// Testbench for mult_share_ctrl with a behavioural multiplier (busy for NB cycles).
`default_nettype none

module tb_mult_share_ctrl;

    localparam int NREQ = 4;
    localparam int NB   = 96;
    localparam int TMO  = 20;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] a_in;
    logic [NREQ*32-1:0] b_in;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [63:0]        result;
    logic               err;
    logic               mul_en;
    logic [31:0]        mul_a;
    logic [31:0]        mul_b;
    logic               mul_busy;
    logic [63:0]        mul_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mult_share_ctrl #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .result(result), .err(err),
        .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_busy(mul_busy), .mul_r(mul_r)
    );

    // Multiplier model: A sampled at start, B read at completion.
    logic        m_busy;
    logic        force_busy;
    int          m_cnt;
    logic [31:0] m_a;
    logic [63:0] m_prod;

    assign m_prod   = {{32{m_a[31]}}, m_a} * {{32{mul_b[31]}}, mul_b};
    assign mul_busy = m_busy | force_busy;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            mul_r  <= '0;
        end else if (!m_busy && mul_en) begin
            m_busy <= 1'b1;
            m_cnt  <= NB;
            m_a    <= mul_a;
        end else if (m_busy) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                mul_r  <= m_prod;
            end
        end
    end

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns the index of the first done strobe seen, or -1 on timeout.
    task automatic wait_done(output int who, output int cyc, output int en_cnt);
        bit seen;
        seen   = 1'b0;
        who    = -1;
        cyc    = 0;
        en_cnt = 0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            cyc++;
            if (mul_en) en_cnt++;
            if (done != '0) begin
                seen = 1'b1;
                for (int j = 0; j < NREQ; j++) if (done[j]) who = j;
                check("done_onehot", 64'($onehot(done)), 64'd1);
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_wait: no done within 400 cycles");
        end
    endtask

    initial begin
        vec_t vecs [5];
        int who, cyc, en;
        int exp_order [3];

        vecs[0] = '{0, 32'd7,          32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1, 32'h8000_0000,  32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[2] = '{3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[3] = '{2, 32'h7FFF_FFFF,  32'd2,         64'h0000_0000_FFFF_FFFE};
        vecs[4] = '{0, 32'd0,          32'd123,       64'h0};

        rst = 1'b1; req = '0; a_in = '0; b_in = '0; force_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_mul_en", 64'(mul_en), 64'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-requester transactions
        for (int v = 0; v < 5; v++) begin
            req = 4'b0001 << vecs[v].idx;
            set_op(vecs[v].idx, vecs[v].a, vecs[v].b);
            wait_done(who, cyc, en);
            check($sformatf("vec%0d_owner", v), 64'(who), 64'(vecs[v].idx));
            check($sformatf("vec%0d_latency", v), 64'(cyc), 64'(3 + NB));
            check($sformatf("vec%0d_en_pulses", v), 64'(en), 64'd1);
            check($sformatf("vec%0d_gnt", v), 64'(gnt), 64'(4'b0001 << vecs[v].idx));
            check($sformatf("vec%0d_result", v), result, vecs[v].exp);
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_gnt_clear", v), 64'(gnt), 64'd0);
            check($sformatf("vec%0d_done_clear", v), 64'(done), 64'd0);
        end

        // All four at once after reset: order 0,1,2,3
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10);
        req = 4'b1111;
        for (int k = 0; k < NREQ; k++) begin
            wait_done(who, cyc, en);
            check($sformatf("all4_order%0d", k), 64'(who), 64'(k));
            check($sformatf("all4_result%0d", k), result, 64'((k + 1) * 10));
            if (who >= 0) req[who] = 1'b0;
            @(negedge clk);
            check($sformatf("all4_single_done%0d", k), 64'(done), 64'd0);
        end
        repeat (5) @(negedge clk);
        check("all4_idle_gnt", 64'(gnt), 64'd0);

        // Requester 2 holds req while 0 arrives mid-operation: 2,0,2
        do_reset();
        exp_order = '{2, 0, 2};
        set_op(2, 32'd11, 32'd3);
        set_op(0, 32'd5, 32'hFFFF_FFFE);
        req = 4'b0100;
        repeat (10) @(negedge clk);
        req[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(who, cyc, en);
            check($sformatf("hold_order%0d", k), 64'(who), 64'(exp_order[k]));
            check($sformatf("hold_result%0d", k), result,
                  (exp_order[k] == 2) ? 64'd33 : 64'hFFFF_FFFF_FFFF_FFF6);
            if (k == 1) req[0] = 1'b0;
            if (k == 2) req = '0;
        end
        @(negedge clk);
        check("hold_gnt_clear", 64'(gnt), 64'd0);

        // Operand toggling during WAIT_DONE must not disturb the op
        do_reset();
        set_op(1, 32'h1234_5678, 32'd9);
        req = 4'b0010;
        repeat (20) @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_op(i, $urandom, $urandom);
        req[3] = 1'b1;
        @(negedge clk);
        check("toggle_mul_a", 64'(mul_a), 64'h1234_5678);
        check("toggle_mul_b", 64'(mul_b), 64'd9);
        check("toggle_gnt", 64'(gnt), 64'b0010);
        req[3] = 1'b0;
        wait_done(who, cyc, en);
        check("toggle_owner", 64'(who), 64'd1);
        check("toggle_result", result, 64'h0000_0000_A3D7_0A38);
        req = '0;
        @(negedge clk);

        // Reset in WAIT_DONE, then re-grant of the pending request
        do_reset();
        set_op(3, 32'd5, 32'd6);
        req = 4'b1000;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_mul_en", 64'(mul_en), 64'd0);
        rst = 1'b0;
        wait_done(who, cyc, en);
        check("midrst_owner", 64'(who), 64'd3);
        check("midrst_latency", 64'(cyc), 64'(3 + NB));
        check("midrst_result", result, 64'd30);
        req = '0;
        @(negedge clk);

`ifdef MULT_TIMEOUT_EN
        // Stuck multiplier: watchdog fires TMO cycles after WAIT_BUSY entry
        do_reset();
        force_busy = 1'b1;
        set_op(0, 32'd3, 32'd4);
        req = 4'b0001;
        wait_done(who, cyc, en);
        check("tmo_owner", 64'(who), 64'd0);
        check("tmo_latency", 64'(cyc), 64'(2 + TMO));
        check("tmo_result", result, 64'd0);
        check("tmo_err", 64'(err), 64'd1);
        req = '0;
        repeat (10) @(negedge clk);
        check("tmo_err_sticky", 64'(err), 64'd1);
        force_busy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("tmo_err_cleared", 64'(err), 64'd0);
`else
        check("no_tmo_err", 64'(err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one 32x32 -> 64-bit booth multiplier among NREQ requesters (odometry, heading, velocity-scaling units in the position subsystem).
- Latches the winning requester's operands, pulses the multiplier start, tracks its busy signal and returns the 64-bit product with a one-cycle done strobe to the owner.
- Sits between the position-computation clients and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 255, max cycles allowed in WAIT_BUSY + WAIT_DONE (used only with MULT_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester; held with operands until its done
- a_in  in  NREQ*32  operand A per requester, slice i = [32*i+31:32*i]
- b_in  in  NREQ*32  operand B per requester, same slicing
- gnt  out  NREQ  one-hot owner of the multiplier, held ISSUE through RESP
- done  out  NREQ  one-cycle strobe to the owner in RESP
- result  out  64  captured product, valid during RESP, held until next capture
- err  out  1  sticky timeout flag, cleared only by rst
- mul_en  out  1  start pulse to multiplier
- mul_a  out  32  operand A to multiplier, registered
- mul_b  out  32  operand B to multiplier, registered
- mul_busy  in  1  multiplier busy
- mul_r  in  64  multiplier product, valid when busy is low after an operation

Behaviour:
- Reset: state=IDLE; gnt=0, done=0, result=0, err=0, mul_en=0, mul_a=0, mul_b=0, rr pointer=NREQ-1. Multiplier shares rst, so a mid-operation reset aborts both. No done is issued for an aborted op.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE, req!=0:
  - Choose the first set req bit scanning from ptr+1 upward, with wrap.
  - Set gnt one-hot, ptr=winner, mul_a/mul_b = winner's operands; go to ISSUE.
  - req==0: stay in IDLE.
- ISSUE: mul_en=1 for exactly this cycle; go to WAIT_BUSY.
- WAIT_BUSY: mul_en=0; on mul_busy=1 go to WAIT_DONE.
- WAIT_DONE: on mul_busy=0, capture result=mul_r; go to RESP.
- RESP: done[owner]=1 for one cycle; next cycle gnt=0, go to IDLE.
- Latency: req sampled at edge 0 -> ISSUE cycle 1 -> done at cycle 3+Nb, where Nb = busy-high cycles (96 for 32 bits x 3 states).
- mul_a/mul_b stay stable from ISSUE through RESP. The multiplier samples A in its start state and B combinationally throughout.
- Operand or req changes by non-owners during an operation are ignored.
- A requester holding req high through its done is treated as a new request. It competes round-robin and gets no back-to-back grant if others are waiting.
- Requests arriving in any non-IDLE state wait; there is no preemption.
- Products are signed two's complement, passed through unchanged.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - An 8..16-bit watchdog counts cycles in WAIT_BUSY + WAIT_DONE.
  - On reaching TIMEOUT: err<=1 (sticky), result<=0, go to RESP (owner still gets done).
  - Counter clears on entry to ISSUE.
- Undefined: no counter; err tied 0; controller waits indefinitely.

Test Plan:
- Single request: req=0001, a0=7, b0=-3 -> gnt=0001, one mul_en pulse, done[0] at cycle 3+Nb, result=64'hFFFFFFFF_FFFFFFEB.
- All four request simultaneously (a_i=i+1, b_i=10) after reset -> grant order 0,1,2,3; results 10,20,30,40; exactly one done per requester.
- Requester 2 holds req continuously while requester 0 requests mid-operation -> order 2,0,2; no double grant to 2.
- Operands of owner and non-owners toggled during WAIT_DONE -> mul_a/mul_b unchanged; result matches the operands latched at grant.
- rst asserted during WAIT_DONE -> next cycle: state IDLE, gnt=0, done=0, mul_en=0; pending req re-granted afterwards with a correct product.
- MULT_TIMEOUT_EN, TIMEOUT=20, mul_busy forced to 1 -> done[owner] at 20 cycles after WAIT_BUSY entry, result=0, err=1 and held until rst.
